prio_encoder_seq: RTL and testbench
===================================

// Module: prio_encoder_seq
// PURPOSE
//  Registered, parametrised successor to the 74148-style 8-to-3 priority encoder.
//  Latches N active-low requests, applies a per-line mask and picks a winner by
//  fixed (highest index) or round-robin priority. Presents the index with a
//  valid/ack handshake. Keeps 74148-style cascade outputs (gs_n, eo_n) for
//  chaining encoders. Sits in front of interrupt/service logic.
// PARAMETERS
//  N     8  number of request lines (2..64)
//  EDGE  0  0 = level mode (pending mirrors requests), 1 = edge mode (sticky until ack)
//  W     $clog2(N)  localparam, code width
// PORTS
//  clk      in   1  rising-edge clock
//  rst      in   1  asynchronous, active-high reset
//  en_n     in   1  active-low encoder enable (74148 EI)
//  req_n    in   N  active-low requests, synchronous to clk
//  mask     in   N  1 = line excluded from arbitration
//  rr_mode  in   1  0 = fixed priority (index N-1 highest), 1 = round-robin
//  ack      in   1  consumer accepts the presented code
//  code     out  W  granted index, stable while valid=1
//  valid    out  1  code is a live grant
//  gs_n     out  1  low = enabled and some eligible request (74148 GS)
//  eo_n     out  1  low = enabled and no eligible request (74148 EO)
//  pending  out  N  registered pending vector (debug/status)
// BEHAVIOUR
//  Reset (async):
//   - pending=0, code=0, valid=0, last=0, state=IDLE, req_q=all-ones.
//   - gs_n=1; eo_n=en_n.
//  Pending update (every clk):
//   - EDGE=0: pending <= ~req_n.
//   - EDGE=1: bit i set on falling edge (req_q[i]=1 & req_n[i]=0). Cleared when
//     ack is accepted for code=i. A new edge in the same cycle as its clear wins
//     (bit stays set).
//  Arbitration:
//   - eligible = pending & ~mask.
//   - Fixed mode: highest set index wins.
//   - RR mode: search downward from start = (last==0 ? N-1 : last-1), wrapping.
//     The last granted index is therefore lowest. Reset last=0 makes the first RR
//     order equal fixed order.
//  FSM, two states:
//   - IDLE: if en_n=0 and eligible!=0, register code=winner and valid<=1, go GRANT.
//   - GRANT: code and valid held regardless of mask or new requests.
//     On ack=1: valid<=0, last<=code, clear pending[code] (EDGE=1), go IDLE.
//     If en_n rises: valid<=0, go IDLE. pending and last are kept. No clear.
//   - ack in IDLE is ignored.
//   - At least one idle cycle separates consecutive grants.
//  Latency:
//   - req_n falls before edge k -> pending set at edge k -> valid=1 after edge k+1.
//   - code keeps its last value when valid=0.
//  Cascade outputs, combinational from registered pending/mask and en_n:
//   - en_n=1 -> gs_n=1, eo_n=1.
//   - en_n=0 -> gs_n = ~|eligible, eo_n = |eligible.
//  Level mode: a request released before ack does not withdraw an issued grant.
// STRUCTURE
//  - Shared header prio_defs.vh: state encodings ST_IDLE/ST_GRANT.
//  - Sub-module prio_pick: combinational. Inputs (vec[N], start[W], rr).
//    Outputs (idx[W], any). Implemented as rotate, fixed-priority find, unrotate.
//    The top level instantiates it once.
// TESTING (N=8)
//  1. EDGE=0, fixed, en_n=0, req_n=8'b11111110 -> valid=1 two cycles later,
//     code=000, gs_n=0, eo_n=1.
//  2. EDGE=0, fixed, req_n=8'b10111110 -> code=110. After ack, with requests held,
//     the next grant is code=110 again.
//  3. rr_mode=1, EDGE=0, req_n=8'b01111110 held, ack each grant -> codes 7,0,7,0...
//     Then all 8 requests low -> 7,6,5,...,0,7.
//  4. EDGE=1: pulse req_n[3] low for 1 cycle -> pending[3] stays set until ack,
//     then 0. Re-pulse req_n[3] in the ack cycle -> pending[3] stays 1.
//  5. mask=8'h80, req_n=8'b01111111 -> no grant, gs_n=1, eo_n=0.
//     en_n=1 -> gs_n=1, eo_n=1. en_n=1 during GRANT -> valid=0 next cycle,
//     pending kept.
//  6. rst asserted mid-GRANT -> valid, code and pending immediately 0, gs_n=1.
//     Release -> first RR grant follows fixed order.

Source files
------------

// File: rtl/prio_encoder_seq_pkg.sv
// Shared definitions for the registered priority encoder: arbiter FSM state encodings.
package prio_encoder_seq_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/prio_encoder_seq_pick.sv
// Combinational winner search: rotate so the search start sits at the top,
// take the highest set bit, then rotate the index back.
module prio_pick #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    input  logic         rr,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [N-1:0] rot;
    int           base;
    int           found;
    int           k;

    // rot[N-1] holds vec[base], rot[N-2] holds vec[base-1], ... wrapping,
    // so a plain highest-index search walks downward from base.
    always_comb begin
        rot   = '0;
        found = 0;
        base  = rr ? int'(start) : N - 1;
        if (base >= N) begin
            base = N - 1;
        end
        for (int j = 0; j < N; j++) begin
            k = j + base + 1;
            if (k >= N) begin
                k = k - N;
            end
            rot[j] = vec[k];
        end
        for (int j = 0; j < N; j++) begin
            if (rot[j]) begin
                found = j;
            end
        end
        k = found + base + 1;
        if (k >= N) begin
            k = k - N;
        end
        idx = W'(k);
        any = |vec;
    end

endmodule

// File: rtl/prio_encoder_seq.sv
// Registered 74148-style priority encoder with mask, fixed/round-robin
// arbitration, valid/ack handshake and cascade outputs.
module prio_encoder_seq
    import prio_encoder_seq_pkg::*;
#(
    parameter  int N    = 8,
    parameter  int EDGE = 0,
    localparam int W    = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_n,
    input  logic [N-1:0] req_n,
    input  logic [N-1:0] mask,
    input  logic         rr_mode,
    input  logic         ack,
    output logic [W-1:0] code,
    output logic         valid,
    output logic         gs_n,
    output logic         eo_n,
    output logic [N-1:0] pending
);

    state_t       state;
    logic [N-1:0] req_q;
    logic [W-1:0] last;
    logic [W-1:0] start;
    logic [N-1:0] eligible;
    logic [N-1:0] clear_vec;
    logic [W-1:0] win_idx;
    logic         win_any;

    assign eligible = pending & ~mask;

    // The last granted line becomes the lowest priority in round-robin mode.
    assign start = (last == '0) ? W'(N - 1) : last - W'(1);

    prio_pick #(.N(N)) u_pick (
        .vec   (eligible),
        .start (start),
        .rr    (rr_mode),
        .idx   (win_idx),
        .any   (win_any)
    );

    assign gs_n = en_n | ~win_any;
    assign eo_n = en_n | win_any;

    always_comb begin
        clear_vec = '0;
        if (state == ST_GRANT && ack) begin
            clear_vec[code] = 1'b1;
        end
    end

    // In edge mode a fresh falling edge overrides a simultaneous ack clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            req_q   <= '1;
        end else begin
            req_q <= req_n;
            if (EDGE == 0) begin
                pending <= ~req_n;
            end else begin
                pending <= (pending & ~clear_vec) | (req_q & ~req_n);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            code  <= '0;
            valid <= 1'b0;
            last  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!en_n && win_any) begin
                        code  <= win_idx;
                        valid <= 1'b1;
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (ack) begin
                        valid <= 1'b0;
                        last  <= code;
                        state <= ST_IDLE;
                    end else if (en_n) begin
                        valid <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    valid <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prio_encoder_seq.sv
// Scoreboard bench for prio_encoder_seq: one level-mode and one edge-mode instance, N=8.
module tb_prio_encoder_seq;

    logic       clk;
    logic       rst;
    logic       en_n;
    logic [7:0] req_n;
    logic [7:0] mask;
    logic       rr_mode;
    logic       ack;
    logic [2:0] code;
    logic       valid;
    logic       gs_n;
    logic       eo_n;
    logic [7:0] pending;

    logic       e_en_n;
    logic [7:0] e_req_n;
    logic [7:0] e_mask;
    logic       e_rr_mode;
    logic       e_ack;
    logic [2:0] e_code;
    logic       e_valid;
    logic       e_gs_n;
    logic       e_eo_n;
    logic [7:0] e_pending;

    logic [2:0] exp_q[$];
    int         n_vec;
    int         n_fail;

    prio_encoder_seq #(.N(8), .EDGE(0)) dut_lvl (
        .clk     (clk),
        .rst     (rst),
        .en_n    (en_n),
        .req_n   (req_n),
        .mask    (mask),
        .rr_mode (rr_mode),
        .ack     (ack),
        .code    (code),
        .valid   (valid),
        .gs_n    (gs_n),
        .eo_n    (eo_n),
        .pending (pending)
    );

    prio_encoder_seq #(.N(8), .EDGE(1)) dut_edge (
        .clk     (clk),
        .rst     (rst),
        .en_n    (e_en_n),
        .req_n   (e_req_n),
        .mask    (e_mask),
        .rr_mode (e_rr_mode),
        .ack     (e_ack),
        .code    (e_code),
        .valid   (e_valid),
        .gs_n    (e_gs_n),
        .eo_n    (e_eo_n),
        .pending (e_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation hung");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Change the level-mode request pattern with the encoder disabled so no
    // grant is taken from a stale pending vector, then re-enable.
    task automatic applyStimulus(input logic [7:0] r);
        en_n  = 1'b1;
        req_n = r;
        step(2);
        en_n  = 1'b0;
    endtask

    task automatic serveGrant(input string tag);
        int         waited;
        logic [2:0] want;
        waited = 0;
        while (valid !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (valid !== 1'b1) begin
            checkOutput({tag, "_timeout"}, 64'(valid), 64'(1));
        end else if (exp_q.size() == 0) begin
            checkOutput({tag, "_unexpected"}, 64'(exp_q.size()), 64'(1));
        end else begin
            want = exp_q.pop_front();
            checkOutput(tag, 64'(code), 64'(want));
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
            checkOutput({tag, "_ackdrop"}, 64'(valid), 64'(0));
        end
    endtask

    initial begin
        n_vec     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        en_n      = 1'b1;
        req_n     = 8'hFF;
        mask      = 8'h00;
        rr_mode   = 1'b0;
        ack       = 1'b0;
        e_en_n    = 1'b1;
        e_req_n   = 8'hFF;
        e_mask    = 8'h00;
        e_rr_mode = 1'b0;
        e_ack     = 1'b0;

        #1;
        checkOutput("rst_valid", 64'(valid), 64'(0));
        checkOutput("rst_code", 64'(code), 64'(0));
        checkOutput("rst_pending", 64'(pending), 64'(0));
        checkOutput("rst_gs_n", 64'(gs_n), 64'(1));
        checkOutput("rst_eo_n", 64'(eo_n), 64'(1));
        @(negedge clk);
        rst = 1'b0;

        // Single request on line 0: pending after one edge, grant after two.
        @(negedge clk);
        en_n  = 1'b0;
        req_n = 8'b11111110;
        exp_q.push_back(3'd0);
        step(1);
        checkOutput("t1_valid_early", 64'(valid), 64'(0));
        checkOutput("t1_pending", 64'(pending), 64'(8'h01));
        checkOutput("t1_gs_n", 64'(gs_n), 64'(0));
        checkOutput("t1_eo_n", 64'(eo_n), 64'(1));
        step(1);
        checkOutput("t1_valid", 64'(valid), 64'(1));
        serveGrant("t1_code");

        // Fixed priority repeats the same winner while requests are held.
        applyStimulus(8'b10111110);
        exp_q.push_back(3'd6);
        exp_q.push_back(3'd6);
        serveGrant("t2_first");
        serveGrant("t2_again");

        // Releasing the request does not withdraw an issued grant.
        applyStimulus(8'b11110111);
        exp_q.push_back(3'd3);
        step(1);
        req_n = 8'hFF;
        step(1);
        checkOutput("t2_hold_valid", 64'(valid), 64'(1));
        checkOutput("t2_hold_code", 64'(code), 64'(3));
        checkOutput("t2_hold_pending", 64'(pending), 64'(0));
        serveGrant("t2_hold_grant");

        // Round-robin from a fresh reset.
        @(negedge clk);
        rst = 1'b1;
        step(1);
        rst     = 1'b0;
        rr_mode = 1'b1;
        applyStimulus(8'b01111110);
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd0);
        for (int i = 0; i < 4; i++) serveGrant("t3_pair");
        applyStimulus(8'b00000000);
        for (int i = 0; i < 9; i++) exp_q.push_back(3'((15 - i) % 8));
        for (int i = 0; i < 9; i++) serveGrant("t3_all");

        // Masked-only request, enable gating, and enable dropped mid-grant.
        rr_mode = 1'b0;
        mask    = 8'h80;
        applyStimulus(8'b01111111);
        step(3);
        checkOutput("t5_no_grant", 64'(valid), 64'(0));
        checkOutput("t5_gs_n", 64'(gs_n), 64'(1));
        checkOutput("t5_eo_n", 64'(eo_n), 64'(0));
        en_n = 1'b1;
        #1;
        checkOutput("t5_dis_gs_n", 64'(gs_n), 64'(1));
        checkOutput("t5_dis_eo_n", 64'(eo_n), 64'(1));
        mask = 8'h00;
        en_n = 1'b0;
        step(1);
        checkOutput("t5_grant_valid", 64'(valid), 64'(1));
        checkOutput("t5_grant_code", 64'(code), 64'(7));
        en_n = 1'b1;
        step(1);
        checkOutput("t5_abort_valid", 64'(valid), 64'(0));
        checkOutput("t5_abort_code", 64'(code), 64'(7));
        checkOutput("t5_abort_pending", 64'(pending), 64'(8'h80));

        // Reset during a grant clears last, so RR restarts in fixed order.
        rr_mode = 1'b1;
        applyStimulus(8'b11010111);
        exp_q.push_back(3'd5);
        serveGrant("t6_pre");
        step(1);
        checkOutput("t6_mid_valid", 64'(valid), 64'(1));
        checkOutput("t6_mid_code", 64'(code), 64'(3));
        #1;
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_valid", 64'(valid), 64'(0));
        checkOutput("t6_rst_code", 64'(code), 64'(0));
        checkOutput("t6_rst_pending", 64'(pending), 64'(0));
        checkOutput("t6_rst_gs_n", 64'(gs_n), 64'(1));
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(3'd5);
        serveGrant("t6_first_rr");

        // Edge mode: a one-cycle pulse stays pending until acknowledged.
        en_n   = 1'b1;
        e_en_n = 1'b0;
        e_req_n = 8'hF7;
        step(1);
        e_req_n = 8'hFF;
        checkOutput("t4_set_pending", 64'(e_pending), 64'(8'h08));
        checkOutput("t4_set_valid", 64'(e_valid), 64'(0));
        step(1);
        checkOutput("t4_grant_valid", 64'(e_valid), 64'(1));
        checkOutput("t4_grant_code", 64'(e_code), 64'(3));
        step(2);
        checkOutput("t4_sticky", 64'(e_pending), 64'(8'h08));
        e_ack = 1'b1;
        step(1);
        e_ack = 1'b0;
        checkOutput("t4_clear_pending", 64'(e_pending), 64'(0));
        checkOutput("t4_clear_valid", 64'(e_valid), 64'(0));

        e_req_n = 8'hF7;
        step(1);
        e_req_n = 8'hFF;
        step(1);
        checkOutput("t4_regrant_valid", 64'(e_valid), 64'(1));
        e_ack   = 1'b1;
        e_req_n = 8'hF7;
        step(1);
        e_ack   = 1'b0;
        e_req_n = 8'hFF;
        checkOutput("t4_race_pending", 64'(e_pending), 64'(8'h08));
        checkOutput("t4_race_valid", 64'(e_valid), 64'(0));
        step(1);
        checkOutput("t4_race_grant", 64'(e_valid), 64'(1));
        checkOutput("t4_race_code", 64'(e_code), 64'(3));
        e_ack = 1'b1;
        step(1);
        e_ack = 1'b0;
        checkOutput("t4_final_pending", 64'(e_pending), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
